ex_mem_reg: RTL
===============

Name: ex_mem_reg

Overview:
- Pipeline register between the execute stage and the memory-access stage of the five-stage MIPS pipeline.
- Captures the execute stage's destination-register, write-enable, write-data and HI/LO results each cycle and presents them to the memory-access stage.
- Honours the pipeline stall vector and flush, inserting bubbles when execute stalls but memory does not.
- Carries the two-cycle multiply-accumulate state (partial HI/LO product plus cycle counter) back to the execute stage across stall cycles.

Parameters:
- DATA_W, 32, width of register data, HI, LO.
- ADDR_W, 5, width of register-file address.
- STALL_W, 6, width of pipeline stall vector (bit 0 = PC ... bit 5 = write-back).
- CNT_W, 2, width of multi-cycle counter.

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge.
- rst  input  1  synchronous active-low reset; rst==0 sampled at rising edge resets the block.
- stall  input  STALL_W  stall vector; bit 3 = execute stalled, bit 4 = memory stage stalled.
- flush  input  1  exception flush; kills the held instruction.
- ex_wd  input  ADDR_W  execute destination register address.
- ex_wreg  input  1  execute register write enable.
- ex_wdata  input  DATA_W  execute result.
- ex_whilo  input  1  execute HI/LO write enable.
- ex_hi  input  DATA_W  execute HI result.
- ex_lo  input  DATA_W  execute LO result.
- hilo_temp_i  input  2*DATA_W  partial product from execute (multi-cycle op).
- cnt_i  input  CNT_W  execute multi-cycle counter.
- mem_wd  output  ADDR_W  registered destination address to memory stage.
- mem_wreg  output  1  registered write enable.
- mem_wdata  output  DATA_W  registered result.
- mem_whilo  output  1  registered HI/LO write enable.
- mem_hi  output  DATA_W  registered HI.
- mem_lo  output  DATA_W  registered LO.
- mem_valid  output  1  1 when the register holds a real instruction, 0 for bubble.
- hilo_temp_o  output  2*DATA_W  partial product fed back to execute.
- cnt_o  output  CNT_W  counter fed back to execute.

Behaviour:
- All outputs are registered; latency is 1 cycle from ex_* to mem_*. No combinational path from input to output.
- Priority per rising edge, highest first:
  1. rst==0 (reset): all outputs 0 (mem_wd=0 is the NOP register address, mem_wreg=0, mem_whilo=0, mem_valid=0, hilo_temp_o=0, cnt_o=0).
  2. flush==1: identical to reset, including clearing hilo_temp_o and cnt_o. This aborts any in-flight multi-cycle op.
  3. stall[3]==1 and stall[4]==0 (bubble): mem_wd=0, mem_wreg=0, mem_wdata=0, mem_whilo=0, mem_hi=0, mem_lo=0, mem_valid=0. hilo_temp_o<=hilo_temp_i and cnt_o<=cnt_i, so the stalled execute stage sees its accumulation state next cycle.
  4. stall[3]==0 (advance): all mem_* outputs <= the corresponding ex_* inputs, mem_valid<=1, hilo_temp_o<=0, cnt_o<=0.
  5. Otherwise (stall[3]==1 and stall[4]==1): every output holds its value.
- stall[3]==0 with stall[4]==1 is an illegal stall vector (stalls are monotonic toward earlier stages). The block takes the advance path; the bench asserts this combination never occurs.
- No arithmetic is done; widths pass straight through. hilo_temp_o is {hi_part, lo_part}, with bits [2*DATA_W-1:DATA_W] as HI.
- A deasserted reset or flush takes effect only at a clock edge; between edges outputs keep their last registered value.
- Stall, flush and reset bits other than stall[3] and stall[4] are ignored.

Test Plan:
- Reset: drive rst=0 for 2 cycles with ex_wdata=32'hDEADBEEF and ex_wreg=1 -> all outputs 0 and mem_valid=0. Release rst=1 with stall=0 -> next edge mem_wdata=32'hDEADBEEF, mem_wd=ex_wd, mem_valid=1.
- Streaming: 4 back-to-back instructions with ex_wd=1..4 and ex_wdata=32'h11,32'h22,32'h33,32'h44, stall=0 -> mem_* reproduces the sequence exactly 1 cycle later, with hilo_temp_o=0 and cnt_o=0 throughout.
- Multi-cycle bubble: stall=6'b001111, hilo_temp_i=64'h0000_0001_FFFF_FFFE, cnt_i=1 -> next cycle mem_wreg=0, mem_valid=0, hilo_temp_o=64'h0000_0001_FFFF_FFFE, cnt_o=1. Then stall=0 with ex_whilo=1, ex_hi=32'h2, ex_lo=32'h3 -> mem_whilo=1, mem_hi=2, mem_lo=3, cnt_o=0.
- Hold: load mem_wdata=32'hA5A5A5A5, then stall=6'b011111 for 3 cycles while ex_wdata changes every cycle -> all outputs stay constant (mem_wdata=32'hA5A5A5A5, mem_valid=1).
- Flush priority: flush=1 together with stall=6'b001111 and cnt_i=1 -> next edge all outputs 0, including cnt_o=0. Then rst=0 and flush=1 in the same cycle -> outputs 0 (reset path).
- Reset mid-hold: during a stall=6'b011111 hold with mem_valid=1, assert rst=0 for 1 cycle -> outputs 0 at that edge. After release the block resumes on the advance path when stall=0.

Source files
------------

// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg
//   Pipeline register between the execute stage and the memory-access stage
//   of a five-stage MIPS pipeline. It captures the execute results each cycle
//   and presents them to the memory stage one cycle later.
//
//   During a multi-cycle multiply-accumulate, it also returns the partial
//   HI/LO product and the cycle counter to the execute stage.
//
//   Every output is registered. No combinational path runs from input to
//   output.
//
// Ports
//   clk          pipeline clock; all state changes on the rising edge
//   rst          synchronous active-low reset
//   stall        stall vector; bit 3 = execute stalled, bit 4 = memory stalled
//   flush        exception flush; clears everything, like reset
//   ex_wd        execute destination register address
//   ex_wreg      execute register write enable
//   ex_wdata     execute result
//   ex_whilo     execute HI/LO write enable
//   ex_hi/ex_lo  execute HI/LO results
//   hilo_temp_i  partial product from execute, {HI, LO}
//   cnt_i        execute multi-cycle counter
//   mem_*        registered copies of the ex_* fields for the memory stage
//   mem_valid    1 = real instruction, 0 = bubble
//   hilo_temp_o  partial product fed back to execute, {HI, LO}
//   cnt_o        multi-cycle counter fed back to execute
// ---------------------------------------------------------------------------
module ex_mem_reg #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 6,
    parameter int CNT_W   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic                ex_whilo,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic [2*DATA_W-1:0] hilo_temp_i,
    input  logic [CNT_W-1:0]    cnt_i,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_whilo,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic                mem_valid,
    output logic [2*DATA_W-1:0] hilo_temp_o,
    output logic [CNT_W-1:0]    cnt_o
);

    logic [ADDR_W-1:0]   wd_q,        wd_d;
    logic                wreg_q,      wreg_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic                whilo_q,     whilo_d;
    logic [DATA_W-1:0]   hi_q,        hi_d;
    logic [DATA_W-1:0]   lo_q,        lo_d;
    logic                valid_q,     valid_d;
    logic [2*DATA_W-1:0] hilo_temp_q, hilo_temp_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;

    logic ex_stall;
    logic mem_stall;

    assign ex_stall  = stall[3];
    assign mem_stall = stall[4];

    // Only the execute and memory stall bits affect this stage.
    logic unused_stall;
    assign unused_stall = ^{stall[STALL_W-1:5], stall[2:0]};

    always_comb begin
        // Default: hold. This covers the case where both execute and memory
        // are stalled.
        wd_d        = wd_q;
        wreg_d      = wreg_q;
        wdata_d     = wdata_q;
        whilo_d     = whilo_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        valid_d     = valid_q;
        hilo_temp_d = hilo_temp_q;
        cnt_d       = cnt_q;

        if (flush) begin
            // The flush also aborts any multiply-accumulate still in flight.
            wd_d        = '0;
            wreg_d      = 1'b0;
            wdata_d     = '0;
            whilo_d     = 1'b0;
            hi_d        = '0;
            lo_d        = '0;
            valid_d     = 1'b0;
            hilo_temp_d = '0;
            cnt_d       = '0;
        end else if (ex_stall && !mem_stall) begin
            // Execute is stalled but memory moves on, so insert a bubble.
            // Loop the accumulation state back so the stalled execute stage
            // can continue from where it left off.
            wd_d        = '0;
            wreg_d      = 1'b0;
            wdata_d     = '0;
            whilo_d     = 1'b0;
            hi_d        = '0;
            lo_d        = '0;
            valid_d     = 1'b0;
            hilo_temp_d = hilo_temp_i;
            cnt_d       = cnt_i;
        end else if (!ex_stall) begin
            // Advance. The illegal vector (execute running, memory stalled)
            // also takes this path.
            wd_d        = ex_wd;
            wreg_d      = ex_wreg;
            wdata_d     = ex_wdata;
            whilo_d     = ex_whilo;
            hi_d        = ex_hi;
            lo_d        = ex_lo;
            valid_d     = 1'b1;
            hilo_temp_d = '0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_q        <= '0;
            wreg_q      <= 1'b0;
            wdata_q     <= '0;
            whilo_q     <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            valid_q     <= 1'b0;
            hilo_temp_q <= '0;
            cnt_q       <= '0;
        end else begin
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            wdata_q     <= wdata_d;
            whilo_q     <= whilo_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            valid_q     <= valid_d;
            hilo_temp_q <= hilo_temp_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_wd      = wd_q;
    assign mem_wreg    = wreg_q;
    assign mem_wdata   = wdata_q;
    assign mem_whilo   = whilo_q;
    assign mem_hi      = hi_q;
    assign mem_lo      = lo_q;
    assign mem_valid   = valid_q;
    assign hilo_temp_o = hilo_temp_q;
    assign cnt_o       = cnt_q;

endmodule
